// File: rtl/change_payout_if.sv
`default_nettype none
// ============================================================================
// Module   : change_payout_if
// Brief    : Request, hopper, refill and status signals of the change payout.
// Revision : 1.0
// ============================================================================
interface change_payout_if;
    logic       change_req;
    logic [1:0] change_amt;
    logic       req_ready;
    logic       eject5;
    logic       eject10;
    logic       hopper_ack;
    logic       refill5;
    logic       refill10;
    logic [3:0] inv5;
    logic [3:0] inv10;
    logic       busy;
    logic       done;
    logic       fault;
    logic [1:0] shortfall;

    modport master (
        output change_req, change_amt, hopper_ack, refill5, refill10,
        input  req_ready, eject5, eject10, inv5, inv10, busy, done, fault, shortfall
    );

    modport slave (
        input  change_req, change_amt, hopper_ack, refill5, refill10,
        output req_ready, eject5, eject10, inv5, inv10, busy, done, fault, shortfall
    );
endinterface
`default_nettype wire

// File: rtl/change_payout.sv
`default_nettype none
// ============================================================================
// Module   : change_payout
// Brief    : Pays change in 5/10-unit coins from a tracked hopper inventory.
//            Optional WAIT_ACK timeout enabled by CHANGE_PAYOUT_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module change_payout #(
    parameter int INV5_INIT   = 4,
    parameter int INV10_INIT  = 4,
    parameter int ACK_TIMEOUT = 8
) (
    input  wire logic       clk,
    input  wire logic       reset,
    change_payout_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_EJECT    = 3'd1,
        S_WAIT_ACK = 3'd2,
        S_DONE     = 3'd3,
        S_FAULT    = 3'd4
    } state_t;

    state_t     r_state, w_next;
    logic [1:0] r_remaining, w_remaining_next;
    logic       r_coin10, w_coin10_next;
    logic [3:0] r_inv5, r_inv10;
    logic       w_pick10, w_pick5, w_ack, w_tmo_hit;

    if (ACK_TIMEOUT < 1) begin : g_bad_timeout
        $error("ACK_TIMEOUT must be at least 1");
    end

    // Larger coin first; fall back to 5s when no 10s remain.
    assign w_pick10 = (r_remaining >= 2'd2) && (r_inv10 != 4'd0);
    assign w_pick5  = !w_pick10 && (r_inv5 != 4'd0);
    assign w_ack    = (r_state == S_WAIT_ACK) && bus.hopper_ack;

`ifdef CHANGE_PAYOUT_TIMEOUT_EN
    localparam int c_TMO_W = $clog2(ACK_TIMEOUT + 1);
    logic [c_TMO_W-1:0] r_tmo;

    always_ff @(posedge clk) begin
        if (reset || r_state != S_WAIT_ACK) r_tmo <= '0;
        else                                r_tmo <= r_tmo + 1'b1;
    end

    assign w_tmo_hit = (r_tmo == c_TMO_W'(ACK_TIMEOUT - 1));
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_remaining <= 2'd0;
            r_coin10    <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_remaining <= w_remaining_next;
            r_coin10    <= w_coin10_next;
        end
    end

    always_comb begin
        w_next           = r_state;
        w_remaining_next = r_remaining;
        w_coin10_next    = r_coin10;
        case (r_state)
            S_IDLE: begin
                if (bus.change_req) begin
                    if (bus.change_amt != 2'b00) begin
                        w_remaining_next = bus.change_amt;
                        w_next           = S_EJECT;
                    end else begin
                        w_next = S_DONE;
                    end
                end
            end
            S_EJECT: begin
                if (w_pick10) begin
                    w_coin10_next = 1'b1;
                    w_next        = S_WAIT_ACK;
                end else if (w_pick5) begin
                    w_coin10_next = 1'b0;
                    w_next        = S_WAIT_ACK;
                end else begin
                    w_next = S_FAULT;
                end
            end
            S_WAIT_ACK: begin
                if (bus.hopper_ack) begin
                    w_remaining_next = r_remaining - (r_coin10 ? 2'd2 : 2'd1);
                    w_next = (w_remaining_next == 2'd0) ? S_DONE : S_EJECT;
                end else if (w_tmo_hit) begin
                    w_next = S_FAULT;
                end
            end
            S_DONE:  w_next = S_IDLE;
            S_FAULT: w_next = S_FAULT;
            default: w_next = S_IDLE;
        endcase
    end

    // A refill and an acked drop in the same cycle cancel out.
    function automatic logic [3:0] f_inv_next(input logic [3:0] cur, input logic inc,
                                              input logic dec);
        case ({inc, dec})
            2'b10:   f_inv_next = (cur == 4'd15) ? cur : cur + 4'd1;
            2'b01:   f_inv_next = cur - 4'd1;
            default: f_inv_next = cur;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_inv5  <= 4'(INV5_INIT);
            r_inv10 <= 4'(INV10_INIT);
        end else begin
            r_inv5  <= f_inv_next(r_inv5,  bus.refill5,  w_ack && !r_coin10);
            r_inv10 <= f_inv_next(r_inv10, bus.refill10, w_ack &&  r_coin10);
        end
    end

    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.eject10   = (r_state == S_EJECT) && w_pick10;
    assign bus.eject5    = (r_state == S_EJECT) && w_pick5;
    assign bus.done      = (r_state == S_DONE);
    assign bus.fault     = (r_state == S_FAULT);
    assign bus.shortfall = (r_state == S_FAULT) ? r_remaining : 2'd0;
    assign bus.inv5      = r_inv5;
    assign bus.inv10     = r_inv10;

endmodule
`default_nettype wire

// File: tb/tb_change_payout.sv
`default_nettype none
// ============================================================================
// Module   : tb_change_payout
// Brief    : Directed self-checking bench for change_payout.
// Revision : 1.0
// ============================================================================
module tb_change_payout;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    change_payout_if bus ();

    change_payout #(
        .INV5_INIT  (4),
        .INV10_INIT (4),
        .ACK_TIMEOUT(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        reset = 1'b1;
        bus.change_req = 1'b0;
        bus.change_amt = 2'b00;
        bus.hopper_ack = 1'b0;
        bus.refill5    = 1'b0;
        bus.refill10   = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Issue one request and ack every eject one cycle later; c counts cycles after acceptance.
    task automatic run_payout(input logic [1:0] amt, output int n5, output int n10,
                              output int nboth, output int ndone, output int done_cyc,
                              output int first10, output bit finished);
        bit pend;
        n5 = 0; n10 = 0; nboth = 0; ndone = 0; done_cyc = -1; first10 = -1;
        finished = 1'b0; pend = 1'b0;
        bus.change_req = 1'b1;
        bus.change_amt = amt;
        @(negedge clk);
        bus.change_req = 1'b0;
        bus.change_amt = 2'b00;
        for (int c = 1; c <= 20; c++) begin
            bus.hopper_ack = pend;
            pend = 1'b0;
            if (bus.eject5 && bus.eject10) nboth++;
            if (bus.eject10) begin
                n10++; pend = 1'b1;
                if (first10 < 0) first10 = 1;
            end else if (bus.eject5) begin
                n5++; pend = 1'b1;
                if (first10 < 0) first10 = 0;
            end
            if (bus.done) begin ndone++; done_cyc = c; end
            if (c > 1 && bus.req_ready) begin finished = 1'b1; break; end
            @(negedge clk);
        end
        bus.hopper_ack = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready); end
        n_cmp++; if ({bus.eject5, bus.eject10, bus.busy, bus.done, bus.fault} !== 5'b0) begin n_err++; $display("FAIL reset_flags: got %b expected 00000", {bus.eject5, bus.eject10, bus.busy, bus.done, bus.fault}); end
        n_cmp++; if (bus.shortfall !== 2'd0) begin n_err++; $display("FAIL reset_shortfall: got %0d expected 0", bus.shortfall); end
        n_cmp++; if (bus.inv5 !== 4'd4 || bus.inv10 !== 4'd4) begin n_err++; $display("FAIL reset_inv: got %0d/%0d expected 4/4", bus.inv5, bus.inv10); end
    endtask

    task automatic test_pay5();
        int n5, n10, nb, nd, dc, f10; bit fin;
        do_reset();
        run_payout(2'b01, n5, n10, nb, nd, dc, f10, fin);
        n_cmp++; if (!fin) begin n_err++; $display("FAIL pay5_finish: no return to idle within 20 cycles"); end
        n_cmp++; if (n5 !== 1 || n10 !== 0) begin n_err++; $display("FAIL pay5_ejects: got %0d x5 %0d x10 expected 1 x5 0 x10", n5, n10); end
        n_cmp++; if (nd !== 1 || dc !== 3) begin n_err++; $display("FAIL pay5_done: got %0d pulses at k+%0d expected 1 at k+3", nd, dc); end
        n_cmp++; if (bus.inv5 !== 4'd3 || bus.inv10 !== 4'd4) begin n_err++; $display("FAIL pay5_inv: got %0d/%0d expected 3/4", bus.inv5, bus.inv10); end
    endtask

    task automatic test_pay15();
        int n5, n10, nb, nd, dc, f10; bit fin;
        do_reset();
        run_payout(2'b11, n5, n10, nb, nd, dc, f10, fin);
        n_cmp++; if (n5 !== 1 || n10 !== 1 || nb !== 0) begin n_err++; $display("FAIL pay15_ejects: got %0d x5 %0d x10 %0d both expected 1 1 0", n5, n10, nb); end
        n_cmp++; if (f10 !== 1) begin n_err++; $display("FAIL pay15_order: first coin10=%0d expected 1", f10); end
        n_cmp++; if (nd !== 1 || dc !== 5 || !fin) begin n_err++; $display("FAIL pay15_done: got %0d pulses at k+%0d fin=%0d expected 1 at k+5", nd, dc, fin); end
        n_cmp++; if (bus.inv5 !== 4'd3 || bus.inv10 !== 4'd3) begin n_err++; $display("FAIL pay15_inv: got %0d/%0d expected 3/3", bus.inv5, bus.inv10); end
    endtask

    task automatic test_zero();
        int n5, n10, nb, nd, dc, f10; bit fin;
        do_reset();
        run_payout(2'b00, n5, n10, nb, nd, dc, f10, fin);
        n_cmp++; if (n5 !== 0 || n10 !== 0 || nd !== 1 || dc !== 1) begin n_err++; $display("FAIL zero_amt: got %0d/%0d ejects %0d done at k+%0d expected 0/0 1 at k+1", n5, n10, nd, dc); end
    endtask

    task automatic test_drain10();
        int n5, n10, nb, nd, dc, f10; bit fin;
        do_reset();
        for (int i = 0; i < 4; i++) run_payout(2'b10, n5, n10, nb, nd, dc, f10, fin);
        n_cmp++; if (bus.inv10 !== 4'd0 || bus.inv5 !== 4'd4) begin n_err++; $display("FAIL drain10_inv: got %0d/%0d expected 4/0", bus.inv5, bus.inv10); end
        run_payout(2'b10, n5, n10, nb, nd, dc, f10, fin);
        n_cmp++; if (n5 !== 2 || n10 !== 0) begin n_err++; $display("FAIL drain10_ejects: got %0d x5 %0d x10 expected 2 0", n5, n10); end
        n_cmp++; if (nd !== 1 || !fin) begin n_err++; $display("FAIL drain10_done: got %0d pulses fin=%0d expected 1", nd, fin); end
        n_cmp++; if (bus.inv5 !== 4'd2) begin n_err++; $display("FAIL drain10_inv5: got %0d expected 2", bus.inv5); end
    endtask

    task automatic test_fault();
        int n5, n10, nb, nd, dc, f10; bit fin;
        do_reset();
        for (int i = 0; i < 6; i++) run_payout(2'b10, n5, n10, nb, nd, dc, f10, fin);
        n_cmp++; if (bus.inv5 !== 4'd0 || bus.inv10 !== 4'd0) begin n_err++; $display("FAIL fault_empty: got %0d/%0d expected 0/0", bus.inv5, bus.inv10); end
        bus.change_req = 1'b1; bus.change_amt = 2'b01;
        @(negedge clk);
        bus.change_req = 1'b0; bus.change_amt = 2'b00;
        n_cmp++; if (bus.eject5 !== 1'b0 || bus.eject10 !== 1'b0) begin n_err++; $display("FAIL fault_no_eject: got %b%b expected 00", bus.eject5, bus.eject10); end
        @(negedge clk);
        n_cmp++; if (bus.fault !== 1'b1 || bus.shortfall !== 2'd1 || bus.busy !== 1'b1) begin n_err++; $display("FAIL fault_enter: fault=%b short=%0d busy=%b expected 1 1 1", bus.fault, bus.shortfall, bus.busy); end
        bus.refill5 = 1'b1;
        bus.change_req = 1'b1; bus.change_amt = 2'b01;
        @(negedge clk);
        bus.refill5 = 1'b0;
        bus.change_req = 1'b0; bus.change_amt = 2'b00;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.inv5 !== 4'd1 || bus.fault !== 1'b1 || bus.shortfall !== 2'd1) begin n_err++; $display("FAIL fault_refill: inv5=%0d fault=%b short=%0d expected 1 1 1", bus.inv5, bus.fault, bus.shortfall); end
    endtask

    task automatic test_refill();
        do_reset();
        bus.change_req = 1'b1; bus.change_amt = 2'b10;
        @(negedge clk);
        bus.change_req = 1'b0; bus.change_amt = 2'b00;
        n_cmp++; if (bus.eject10 !== 1'b1) begin n_err++; $display("FAIL refill_eject10: got %b expected 1", bus.eject10); end
        @(negedge clk);
        bus.hopper_ack = 1'b1; bus.refill10 = 1'b1;
        @(negedge clk);
        bus.hopper_ack = 1'b0; bus.refill10 = 1'b0;
        n_cmp++; if (bus.inv10 !== 4'd4 || bus.done !== 1'b1) begin n_err++; $display("FAIL refill_same_cycle: inv10=%0d done=%b expected 4 1", bus.inv10, bus.done); end
        bus.refill10 = 1'b1;
        @(negedge clk);
        bus.refill10 = 1'b0;
        n_cmp++; if (bus.inv10 !== 4'd5) begin n_err++; $display("FAIL refill10_inc: got %0d expected 5", bus.inv10); end
        bus.refill5 = 1'b1;
        repeat (11) @(negedge clk);
        n_cmp++; if (bus.inv5 !== 4'd15) begin n_err++; $display("FAIL refill5_reach15: got %0d expected 15", bus.inv5); end
        @(negedge clk);
        bus.refill5 = 1'b0;
        n_cmp++; if (bus.inv5 !== 4'd15) begin n_err++; $display("FAIL refill5_saturate: got %0d expected 15", bus.inv5); end
    endtask

    task automatic test_timeout();
        do_reset();
        bus.change_req = 1'b1; bus.change_amt = 2'b11;
        @(negedge clk);
        bus.change_req = 1'b0; bus.change_amt = 2'b00;
        n_cmp++; if (bus.eject10 !== 1'b1) begin n_err++; $display("FAIL timeout_eject10: got %b expected 1", bus.eject10); end
`ifdef CHANGE_PAYOUT_TIMEOUT_EN
        repeat (8) @(negedge clk);
        n_cmp++; if (bus.fault !== 1'b0) begin n_err++; $display("FAIL timeout_early: fault=%b at k+9 expected 0", bus.fault); end
        @(negedge clk);
        n_cmp++; if (bus.fault !== 1'b1 || bus.shortfall !== 2'd3 || bus.inv10 !== 4'd4) begin n_err++; $display("FAIL timeout_fault: fault=%b short=%0d inv10=%0d expected 1 3 4", bus.fault, bus.shortfall, bus.inv10); end
`else
        repeat (100) @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b1 || bus.fault !== 1'b0 || bus.eject10 !== 1'b0) begin n_err++; $display("FAIL wait_forever: busy=%b fault=%b ej10=%b expected 1 0 0", bus.busy, bus.fault, bus.eject10); end
        n_cmp++; if (bus.inv10 !== 4'd4 || bus.shortfall !== 2'd0) begin n_err++; $display("FAIL wait_forever_inv: inv10=%0d short=%0d expected 4 0", bus.inv10, bus.shortfall); end
`endif
        do_reset();
        n_cmp++; if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_mid_payout: ready=%b busy=%b expected 1 0", bus.req_ready, bus.busy); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus.change_req = 1'b0;
        bus.change_amt = 2'b00;
        bus.hopper_ack = 1'b0;
        bus.refill5    = 1'b0;
        bus.refill10   = 1'b0;
        @(negedge clk);
        test_reset();
        test_pay5();
        test_pay15();
        test_zero();
        test_drain10();
        test_fault();
        test_refill();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/change_payout.md
CHANGE_PAYOUT -- requirements
Module: change_payout

Interface
REQ-001 Parameter INV5_INIT, default 4: 5-unit coin inventory loaded at reset.
REQ-002 Parameter INV10_INIT, default 4: 10-unit coin inventory loaded at reset.
REQ-003 Parameter ACK_TIMEOUT, default 8: maximum cycles spent in WAIT_ACK (only with CHANGE_PAYOUT_TIMEOUT_EN).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 change_req  input  1  change request valid, sampled only when req_ready=1.
REQ-007 change_amt  input  2  change code: 00 none, 01 5 units, 10 10 units, 11 15 units.
REQ-008 req_ready  output  1  high only in IDLE.
REQ-009 eject5  output  1  command to the hopper to drop one 5-unit coin.
REQ-010 eject10  output  1  command to the hopper to drop one 10-unit coin.
REQ-011 hopper_ack  input  1  hopper confirms that the commanded coin has dropped.
REQ-012 refill5, refill10  input  1 each  each pulse adds one coin of that denomination to inventory.
REQ-013 inv5, inv10  output  4 each  current inventory counts, saturating at 15.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse when a payout completes in full.
REQ-016 fault  output  1  high in FAULT.
REQ-017 shortfall  output  2  unpaid amount in 5-unit steps, valid while fault=1, otherwise 0.

Function
REQ-018 States SHALL be IDLE, EJECT, WAIT_ACK, DONE and FAULT, with outputs decoded Moore-style from state and registers.
REQ-019 In IDLE, change_req=1 with a nonzero change_amt SHALL load remaining (2 bits, 5-unit steps) = change_amt and move to EJECT.
REQ-020 In IDLE, change_req=1 with change_amt=00 SHALL go to DONE with no eject.
REQ-021 EJECT coin choice: 10-unit coin if remaining>=2 and inv10>0; else 5-unit coin if inv5>0; else FAULT with shortfall=remaining.
REQ-022 eject5/eject10 SHALL be high for exactly the one EJECT cycle, never both at once; the next state SHALL be WAIT_ACK.
REQ-023 In WAIT_ACK, hopper_ack=1 SHALL subtract the coin value (2 or 1) from remaining and decrement the matching inventory by one.
REQ-024 After the ack, the next state SHALL be DONE if remaining becomes 0, else EJECT.
REQ-025 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-026 hopper_ack outside WAIT_ACK, and change_req outside IDLE, SHALL be ignored.
REQ-027 A refill pulse SHALL increment its inventory and saturate at 15.
REQ-028 Refill of a denomination in the same cycle as its acked decrement SHALL leave that count unchanged.
REQ-029 FAULT SHALL be sticky until reset; refills SHALL still update inventory while in FAULT.
REQ-030 Minimum latency for a 5-unit request accepted at edge k: eject5 high in cycle k+1, ack in cycle k+2, done high in cycle k+3.

Reset
REQ-031 On reset, the state SHALL be IDLE, inv5=INV5_INIT, inv10=INV10_INIT, remaining=0 and the timeout counter=0.
REQ-032 Out of reset, outputs SHALL be: req_ready=1; eject5, eject10, busy, done and fault=0; shortfall=0.
REQ-033 Reset mid-payout SHALL abandon the payout without restoring coins already acked.

Configuration
REQ-034 With CHANGE_PAYOUT_TIMEOUT_EN defined, a counter SHALL clear on WAIT_ACK entry.
REQ-035 With CHANGE_PAYOUT_TIMEOUT_EN defined, ACK_TIMEOUT cycles in WAIT_ACK without hopper_ack SHALL cause FAULT with shortfall=remaining and no inventory change.
REQ-036 Without CHANGE_PAYOUT_TIMEOUT_EN, WAIT_ACK SHALL wait indefinitely and no counter SHALL be built.

Verification
REQ-037 Reset, request amt=01, ack one cycle after eject5 -> one eject5 pulse, inv5 4->3, done pulse at k+3.
REQ-038 Request amt=11 -> eject10 then eject5; inv10=3, inv5=3; single done pulse after the second ack.
REQ-039 inv10 drained to 0, request amt=10 -> two eject5 pulses, inv5 decreases by 2, done pulse.
REQ-040 inv5=0 and inv10=0, request amt=01 -> FAULT, shortfall=01, no eject; refill5 while faulted -> inv5=1, fault stays high.
REQ-041 refill10 in the same cycle as a 10-unit ack -> inv10 unchanged; 12 refill5 pulses from 4 -> inv5 saturates at 15.
REQ-042 With CHANGE_PAYOUT_TIMEOUT_EN defined, withhold hopper_ack -> FAULT after 8 cycles with shortfall=original amount; without the macro -> busy held, no fault after 100 cycles.
